// File: rtl/fwd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fwd_pkg
// Purpose  : Shared types and helpers for the forwarding / hazard controller.
//            Holds the per-stage destination tag, the forward-select encoding
//            and the select-width helper.
// Revision : 1.0 - initial release
// ============================================================================
package fwd_pkg;

  // Tag register-address fields are sized for the widest supported RAW.
  // Narrower addresses are zero-extended at the controller boundary.
  localparam int unsigned TAG_RAW_W = 8;

  typedef struct packed {
    logic                 v;
    logic [TAG_RAW_W-1:0] rs;
    logic [TAG_RAW_W-1:0] rt;
    logic [TAG_RAW_W-1:0] rd;
    logic                 regwrite;
    logic                 memread;
  } tag_t;

  // Forward select encoding: 0 = register file, 1.. = EX/MEM lanes,
  // LANES+1.. = MEM/WB lanes.
  localparam int unsigned FWD_RF       = 0;
  localparam int unsigned FWD_MEM_BASE = 1;

  function automatic int unsigned fwd_wb_base(input int unsigned lanes);
    return lanes + 1;
  endfunction

  function automatic int unsigned fwd_selw(input int unsigned lanes);
    return $clog2(2 * lanes + 1);
  endfunction

  // True when tag t is a live producer of architectural register r.
  function automatic logic tag_writes(input tag_t t, input logic [TAG_RAW_W-1:0] r);
    return t.v && t.regwrite && (t.rd != '0) && (t.rd == r);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_match.sv
`default_nettype none
// ============================================================================
// Module   : fwd_match
// Purpose  : Resolves the forward source for one EX-stage operand against
//            all MEM-stage and WB-stage destination tags.
// Ports    : en_i   - consumer lane is valid (else select register file)
//            opnd_i - operand register address
//            mem_i  - MEM-stage tags, one per lane
//            wb_i   - WB-stage tags, one per lane
//            sel_o  - priority-encoded forward select
// Revision : 1.0 - initial release
// ============================================================================
module fwd_match
  import fwd_pkg::*;
#(
  parameter int unsigned LANES = 2,
  parameter int unsigned SELW  = fwd_selw(LANES)
) (
  input  logic                 en_i,
  input  logic [TAG_RAW_W-1:0] opnd_i,
  input  tag_t [LANES-1:0]     mem_i,
  input  tag_t [LANES-1:0]     wb_i,
  output logic [SELW-1:0]      sel_o
);

  localparam int unsigned WB_BASE = fwd_wb_base(LANES);

  // Only v/regwrite/rd take part in matching; the rest of each tag rides along.
  logic unused_tag_bits;
  assign unused_tag_bits = ^{mem_i, wb_i};

  // Later assignments override earlier ones: WB scanned first, then MEM,
  // each in ascending lane order, so MEM beats WB and the youngest lane wins.
  always_comb begin
    sel_o = SELW'(FWD_RF);
    if (en_i) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (tag_writes(wb_i[k], opnd_i)) sel_o = SELW'(WB_BASE + k);
      end
      for (int unsigned k = 0; k < LANES; k++) begin
        if (tag_writes(mem_i[k], opnd_i)) sel_o = SELW'(FWD_MEM_BASE + k);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_ctrl
// Purpose  : Forwarding and hazard controller for a LANES-wide superscalar
//            MIPS pipeline. Tracks EX/MEM/WB destination tags, produces EX
//            operand forward selects, load-use stalls and intra-bundle splits.
// Ports    : clk, rst_n           - clock, async active-low reset
//            id_*_i               - ID-stage bundle description, per lane
//            flush_i              - squash ID bundle and EX stage
//            issue_mask_o         - ID lanes accepted into EX this cycle
//            stall_o              - hold IF/ID
//            fwd_a_o / fwd_b_o    - EX operand A/B source per lane
//            stall_cnt_o / split_cnt_o - only with HAZ_STATS_EN defined
// Config   : HAZ_STATS_EN adds saturating load-use / split event counters.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int unsigned LANES = 2,
  parameter int unsigned RAW   = 5,
  parameter int unsigned SELW  = fwd_selw(LANES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LANES-1:0]      id_valid_i,
  input  logic [LANES*RAW-1:0]  id_rs_i,
  input  logic [LANES*RAW-1:0]  id_rt_i,
  input  logic [LANES-1:0]      id_rt_used_i,
  input  logic [LANES*RAW-1:0]  id_rd_i,
  input  logic [LANES-1:0]      id_regwrite_i,
  input  logic [LANES-1:0]      id_memread_i,
  input  logic                  flush_i,
  output logic [LANES-1:0]      issue_mask_o,
  output logic                  stall_o,
  output logic [LANES*SELW-1:0] fwd_a_o,
  output logic [LANES*SELW-1:0] fwd_b_o
`ifdef HAZ_STATS_EN
  ,
  output logic [31:0]           stall_cnt_o,
  output logic [31:0]           split_cnt_o
`endif
);

  tag_t [LANES-1:0] id_tag;
  tag_t [LANES-1:0] ex_d, ex_q, mem_q, wb_q;
  logic             load_use;
  logic [LANES-1:0] split_mask;

  // ID bundle as tags, register addresses widened to the tag width.
  always_comb begin
    for (int unsigned k = 0; k < LANES; k++) begin
      id_tag[k]          = '0;
      id_tag[k].v        = id_valid_i[k];
      id_tag[k].rs       = TAG_RAW_W'(id_rs_i[k*RAW +: RAW]);
      id_tag[k].rt       = TAG_RAW_W'(id_rt_i[k*RAW +: RAW]);
      id_tag[k].rd       = TAG_RAW_W'(id_rd_i[k*RAW +: RAW]);
      id_tag[k].regwrite = id_regwrite_i[k];
      id_tag[k].memread  = id_memread_i[k];
    end
  end

  // Load in EX feeding any valid ID lane: its data is not ready until MEM/WB.
  always_comb begin
    load_use = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      for (int unsigned j = 0; j < LANES; j++) begin
        if (id_valid_i[j] && ex_q[i].memread &&
            (tag_writes(ex_q[i], id_tag[j].rs) ||
             (id_rt_used_i[j] && tag_writes(ex_q[i], id_tag[j].rt))))
          load_use = 1'b1;
      end
    end
  end

  // Intra-bundle split: once a lane depends on an older lane of the same
  // bundle, it and every younger lane are held back.
  always_comb begin
    logic blocked;
    blocked    = 1'b0;
    split_mask = '0;
    for (int unsigned j = 0; j < LANES; j++) begin
      for (int unsigned i = 0; i < j; i++) begin
        if (id_valid_i[j] &&
            (tag_writes(id_tag[i], id_tag[j].rs) ||
             (id_rt_used_i[j] && tag_writes(id_tag[i], id_tag[j].rt))))
          blocked = 1'b1;
      end
      split_mask[j] = id_valid_i[j] && !blocked;
    end
  end

  assign issue_mask_o = load_use ? '0 : split_mask;
  assign stall_o      = |(id_valid_i & ~issue_mask_o);

  // Flush empties EX regardless of what the hazard logic decided.
  always_comb begin
    for (int unsigned k = 0; k < LANES; k++) begin
      ex_d[k]   = id_tag[k];
      ex_d[k].v = issue_mask_o[k] && !flush_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  // Forward selects depend only on EX/MEM/WB state, so an empty ID bundle
  // does not suppress forwarding for instructions already in EX.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    fwd_match #(.LANES(LANES), .SELW(SELW)) u_match_a (
      .en_i   (ex_q[k].v),
      .opnd_i (ex_q[k].rs),
      .mem_i  (mem_q),
      .wb_i   (wb_q),
      .sel_o  (fwd_a_o[k*SELW +: SELW])
    );
    fwd_match #(.LANES(LANES), .SELW(SELW)) u_match_b (
      .en_i   (ex_q[k].v),
      .opnd_i (ex_q[k].rt),
      .mem_i  (mem_q),
      .wb_i   (wb_q),
      .sel_o  (fwd_b_o[k*SELW +: SELW])
    );
  end

`ifdef HAZ_STATS_EN
  logic [31:0] stall_cnt_q, split_cnt_q;
  logic        split_evt;

  assign split_evt = (issue_mask_o != '0) &&
                     ($countones(issue_mask_o) < $countones(id_valid_i));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      split_cnt_q <= '0;
    end else begin
      if (load_use && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (split_evt && (split_cnt_q != 32'hFFFF_FFFF)) split_cnt_q <= split_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign split_cnt_o = split_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fwd_hazard_ctrl
// Purpose  : Scoreboard bench for fwd_hazard_ctrl. A reference model tracks
//            in-flight instructions as a list (stage, lane, registers) and
//            derives the expected selects, stalls and issue masks.
//            HAZ_STATS_EN also enables the counter checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_ctrl;

  localparam int LANES = 2;
  localparam int RAW   = 5;
  localparam int SELW  = $clog2(2*LANES+1);

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [LANES-1:0]      id_valid = '0, id_rt_used = '0, id_regwrite = '0, id_memread = '0;
  logic [LANES*RAW-1:0]  id_rs = '0, id_rt = '0, id_rd = '0;
  logic                  flush = 1'b0;
  logic [LANES-1:0]      issue_mask;
  logic                  stall;
  logic [LANES*SELW-1:0] fwd_a, fwd_b;
`ifdef HAZ_STATS_EN
  logic [31:0]           stall_cnt, split_cnt;
`endif

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.LANES(LANES), .RAW(RAW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid_i    (id_valid),
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .id_rt_used_i  (id_rt_used),
    .id_rd_i       (id_rd),
    .id_regwrite_i (id_regwrite),
    .id_memread_i  (id_memread),
    .flush_i       (flush),
    .issue_mask_o  (issue_mask),
    .stall_o       (stall),
    .fwd_a_o       (fwd_a),
    .fwd_b_o       (fwd_b)
`ifdef HAZ_STATS_EN
    ,
    .stall_cnt_o   (stall_cnt),
    .split_cnt_o   (split_cnt)
`endif
  );

  // ---------------- reference model ----------------
  typedef struct {
    int stage;   // 0 = EX, 1 = MEM, 2 = WB
    int lane;
    int rs, rt, rd;
    bit rw, mr;
  } instr_t;
  instr_t pipe[$];

  typedef struct {
    logic [LANES-1:0]      issue;
    logic                  stall;
    logic [LANES*SELW-1:0] fa, fb;
    logic [31:0]           sc, pc;
    bit                    lu;
    int                    cyc;
  } exp_t;
  exp_t sb[$];

  // current ID bundle
  bit v[LANES], rtu[LANES], rw[LANES], mr[LANES];
  int rs[LANES], rt[LANES], rd[LANES];

  int n_checks = 0, n_pass = 0, cyc_no = 0;
  logic [31:0] m_sc = 0, m_pc = 0;

  function automatic bit reads(int j, int r);
    return (rs[j] == r) || (rtu[j] && rt[j] == r);
  endfunction

  // Source for an EX consumer reading register r.
  function automatic int src_sel(int r);
    if (r == 0) return 0;
    for (int st = 1; st <= 2; st++) begin
      int hi = -1;
      foreach (pipe[i])
        if (pipe[i].stage == st && pipe[i].rw && pipe[i].rd == r && pipe[i].lane > hi)
          hi = pipe[i].lane;
      if (hi >= 0) return (st == 1) ? 1 + hi : LANES + 1 + hi;
    end
    return 0;
  endfunction

  function automatic exp_t model_expect();
    exp_t e;
    int   first_dep = LANES;
    e = '{default: '0};
    e.lu = 0;
    foreach (pipe[i])
      if (pipe[i].stage == 0 && pipe[i].mr && pipe[i].rw && pipe[i].rd != 0)
        for (int j = 0; j < LANES; j++)
          if (v[j] && reads(j, pipe[i].rd)) e.lu = 1;
    for (int j = LANES-1; j >= 1; j--)
      for (int i = 0; i < j; i++)
        if (v[j] && v[i] && rw[i] && rd[i] != 0 && reads(j, rd[i])) first_dep = j;
    for (int j = 0; j < LANES; j++) begin
      e.issue[j] = !e.lu && v[j] && (j < first_dep);
      if (v[j] && !e.issue[j]) e.stall = 1'b1;
    end
    for (int k = 0; k < LANES; k++) begin
      int sa = 0, sbb = 0;
      foreach (pipe[i])
        if (pipe[i].stage == 0 && pipe[i].lane == k) begin
          sa  = src_sel(pipe[i].rs);
          sbb = src_sel(pipe[i].rt);
        end
      e.fa[k*SELW +: SELW] = SELW'(sa);
      e.fb[k*SELW +: SELW] = SELW'(sbb);
    end
    e.sc  = m_sc;
    e.pc  = m_pc;
    e.cyc = cyc_no;
    return e;
  endfunction

  task automatic model_advance(input bit fl, input exp_t e);
    instr_t nq[$];
    instr_t x;
    int nv = 0, ni = 0;
    foreach (pipe[i]) begin
      x = pipe[i];
      x.stage++;
      if (x.stage <= 2) nq.push_back(x);
    end
    if (!fl)
      for (int k = 0; k < LANES; k++)
        if (e.issue[k])
          nq.push_back('{stage: 0, lane: k, rs: rs[k], rt: rt[k], rd: rd[k], rw: rw[k], mr: mr[k]});
    pipe = nq;
    for (int k = 0; k < LANES; k++) begin
      nv += int'(v[k]);
      ni += int'(e.issue[k]);
    end
    if (e.lu && m_sc != 32'hFFFF_FFFF) m_sc++;
    if (ni > 0 && ni < nv && m_pc != 32'hFFFF_FFFF) m_pc++;
  endtask

  // ---------------- stimulus ----------------
  task automatic clear_bundle();
    for (int k = 0; k < LANES; k++) begin
      v[k] = 0; rtu[k] = 0; rw[k] = 0; mr[k] = 0; rs[k] = 0; rt[k] = 0; rd[k] = 0;
    end
  endtask

  task automatic set_lane(int k, int a, int b, bit bu, int d, bit w, bit m);
    v[k] = 1; rs[k] = a; rt[k] = b; rtu[k] = bu; rd[k] = d; rw[k] = w; mr[k] = m;
  endtask

  task automatic drive(input bit fl);
    flush = fl;
    for (int k = 0; k < LANES; k++) begin
      id_valid[k]            = v[k];
      id_rt_used[k]          = rtu[k];
      id_regwrite[k]         = rw[k];
      id_memread[k]          = mr[k];
      id_rs[k*RAW +: RAW]    = RAW'(rs[k]);
      id_rt[k*RAW +: RAW]    = RAW'(rt[k]);
      id_rd[k*RAW +: RAW]    = RAW'(rd[k]);
    end
  endtask

  // Called at posedge+1: drive, queue expectation, step across next edge.
  task automatic cyc(input bit fl);
    exp_t e;
    drive(fl);
    e = model_expect();
    sb.push_back(e);
    @(posedge clk); #1;
    cyc_no++;
    model_advance(fl, e);
  endtask

  task automatic reset_cyc();
    exp_t e;
    rst_n = 1'b0;
    pipe.delete();
    m_sc = 0;
    m_pc = 0;
    drive(1'b0);
    e = model_expect();
    sb.push_back(e);
    @(posedge clk); #1;
    cyc_no++;
    rst_n = 1'b1;
  endtask

  task automatic idle(int n);
    clear_bundle();
    repeat (n) cyc(1'b0);
  endtask

  // ---------------- monitor ----------------
  task automatic check(string name, int c, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, c, got, exp);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("issue_mask", e.cyc, 32'(issue_mask), 32'(e.issue));
        check("stall",      e.cyc, 32'(stall),      32'(e.stall));
        check("fwd_a",      e.cyc, 32'(fwd_a),      32'(e.fa));
        check("fwd_b",      e.cyc, 32'(fwd_b),      32'(e.fb));
`ifdef HAZ_STATS_EN
        check("stall_cnt",  e.cyc, stall_cnt,       e.sc);
        check("split_cnt",  e.cyc, split_cnt,       e.pc);
`endif
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    clear_bundle();
    @(posedge clk); #1;
    reset_cyc();                    // reset state with empty ID
    idle(1);

    // ALU forward from MEM to lane 1
    clear_bundle(); set_lane(0, 0, 0, 0, 3, 1, 0); cyc(0);
    clear_bundle(); set_lane(0, 1, 2, 1, 10, 1, 0); set_lane(1, 3, 0, 0, 11, 1, 0); cyc(0);
    idle(3);

    // MEM lane 0 beats WB lane 1 for r5
    clear_bundle(); set_lane(1, 0, 0, 0, 5, 1, 0); cyc(0);
    clear_bundle(); set_lane(0, 0, 0, 0, 5, 1, 0); cyc(0);
    clear_bundle(); set_lane(0, 5, 0, 0, 12, 1, 0); cyc(0);
    idle(3);

    // Both MEM lanes write r7: youngest wins
    clear_bundle(); set_lane(0, 1, 0, 0, 7, 1, 0); set_lane(1, 2, 0, 0, 7, 1, 0); cyc(0);
    clear_bundle(); set_lane(0, 7, 7, 1, 13, 1, 0); cyc(0);
    idle(3);

    // r0 producer never forwards
    clear_bundle(); set_lane(0, 1, 0, 0, 0, 1, 0); cyc(0);
    clear_bundle(); set_lane(0, 0, 0, 1, 14, 1, 0); cyc(0);
    idle(3);

    // Load-use: one bubble, then MEM/WB forward
    clear_bundle(); set_lane(0, 1, 0, 0, 4, 1, 1); cyc(0);
    clear_bundle(); set_lane(0, 4, 2, 1, 15, 1, 0); cyc(0);
    cyc(0);
    idle(3);

    // Intra-bundle split, then re-present the unissued lane compacted
    clear_bundle(); set_lane(0, 1, 2, 0, 9, 1, 0); set_lane(1, 9, 0, 0, 16, 1, 0); cyc(0);
    clear_bundle(); set_lane(0, 9, 0, 0, 16, 1, 0); cyc(0);
    idle(3);

    // Flush alongside a load-use stall
    clear_bundle(); set_lane(0, 1, 0, 0, 4, 1, 1); cyc(0);
    clear_bundle(); set_lane(0, 4, 0, 0, 17, 1, 0); cyc(1);
    cyc(0);
    idle(3);

    // Randomized traffic with a mid-run reset
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < LANES; k++) begin
        v[k]   = ($urandom_range(0, 3) != 0);
        rs[k]  = $urandom_range(0, 7);
        rt[k]  = $urandom_range(0, 7);
        rd[k]  = $urandom_range(0, 7);
        rtu[k] = $urandom_range(0, 1);
        rw[k]  = ($urandom_range(0, 3) != 0);
        mr[k]  = ($urandom_range(0, 3) == 0);
      end
      if (n == 200) reset_cyc();
      else cyc($urandom_range(0, 11) == 0);
    end
    idle(2);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
